// File: rtl/led_pwm_blink.sv
// led_pwm_blink: output conditioner between the LED PIO pattern register and
// the board LED pins. Applies global PWM dimming and per-LED blink. Brightness
// is only adopted at PWM period boundaries, so a duty change never glitches a
// period that is already running.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   led_pattern  LED on/off pattern from the PIO out_port
//   brightness   duty setting; 0 = off, all-ones = fully on
//   blink_en     per-LED blink enable
//   led_out      registered LED pin drive, active-high
//   pwm_wrap     one-cycle pulse aligned with pwm_cnt == 0 (period start)
module led_pwm_blink #(
  parameter int unsigned NUM_LEDS  = 10,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned BLINK_W   = 25
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_pattern,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [NUM_LEDS-1:0] blink_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                pwm_wrap
);

  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
  localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Input stage
  logic [NUM_LEDS-1:0] pattern_q;
  logic [NUM_LEDS-1:0] blink_en_q;
  logic [PWM_BITS-1:0] bright_q;

  // PWM state
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] active_bright_q, active_bright_d;
  logic                pwm_wrap_q, pwm_wrap_d;

  // Blink state
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  // Output register
  logic [NUM_LEDS-1:0] led_out_q, led_out_d;

  logic pwm_last;
  logic pwm_on;
  logic blink_last;

  // Next-state logic for the PWM, blink and output registers
  always_comb begin
    pwm_last        = (pwm_cnt_q == PWM_MAX);
    pwm_cnt_d       = pwm_cnt_q + PWM_BITS'(1);
    pwm_wrap_d      = pwm_last;
    // Duty is latched only on the last cycle of a period so it starts cleanly at count 0.
    active_bright_d = pwm_last ? bright_q : active_bright_q;
    // All-ones is forced fully on; otherwise the top step would be 255/256.
    pwm_on          = (active_bright_q == PWM_MAX) || (pwm_cnt_q < active_bright_q);

    blink_last      = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d     = blink_last ? '0 : blink_cnt_q + BLINK_W'(1);
    blink_phase_d   = blink_phase_q ^ blink_last;

    led_out_d       = pattern_q
                    & {NUM_LEDS{pwm_on}}
                    & (~blink_en_q | {NUM_LEDS{blink_phase_q}});
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pattern_q       <= '0;
      blink_en_q      <= '0;
      bright_q        <= '0;
      pwm_cnt_q       <= '0;
      active_bright_q <= '0;
      pwm_wrap_q      <= 1'b0;
      blink_cnt_q     <= '0;
      blink_phase_q   <= 1'b1;
      led_out_q       <= '0;
    end else begin
      pattern_q       <= led_pattern;
      blink_en_q      <= blink_en;
      bright_q        <= brightness;
      pwm_cnt_q       <= pwm_cnt_d;
      active_bright_q <= active_bright_d;
      pwm_wrap_q      <= pwm_wrap_d;
      blink_cnt_q     <= blink_cnt_d;
      blink_phase_q   <= blink_phase_d;
      led_out_q       <= led_out_d;
    end
  end

  assign led_out  = led_out_q;
  assign pwm_wrap = pwm_wrap_q;

endmodule

// File: tb/tb_led_pwm_blink.sv
`timescale 1ns/1ps
module tb_led_pwm_blink;

  localparam int unsigned NL = 10;
  localparam int unsigned PB = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NL-1:0] led_pattern;
  logic [PB-1:0] brightness;
  logic [NL-1:0] blink_en;
  logic [NL-1:0] led_out;
  logic          pwm_wrap;

  int checks = 0;
  int errors = 0;

  led_pwm_blink #(
    .NUM_LEDS (NL),
    .PWM_BITS (PB),
    .BLINK_DIV(4),
    .BLINK_W  (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .led_pattern(led_pattern),
    .brightness (brightness),
    .blink_en   (blink_en),
    .led_out    (led_out),
    .pwm_wrap   (pwm_wrap)
  );

  always #5 clk = ~clk;

  // Expected summary of one PWM window (pwm_wrap cycle through the cycle before the next wrap)
  typedef struct {
    int            cnt;
    logic [NL-1:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [NL-1:0] v);
    exp_t e;
    e.cnt = c;
    e.val = v;
    sb.push_back(e);
  endtask

  // Monitor: summarise each window between pwm_wrap pulses and score it
  logic          in_win = 1'b0;
  int            win_len, hi_cnt;
  logic [NL-1:0] or_v, and_v;

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      in_win = 1'b0;
    end else begin
      if (pwm_wrap === 1'b1) begin
        if (in_win && sb.size() > 0) begin
          e_m = sb.pop_front();
          chk("win_len", 32'(win_len), 32'd256);
          chk("win_hi_cycles", 32'(hi_cnt), 32'(e_m.cnt));
          chk("win_or_value", 32'(or_v), 32'(e_m.val));
          if (e_m.cnt > 0) chk("win_and_value", 32'(and_v), 32'(e_m.val));
        end
        in_win  = 1'b1;
        win_len = 0;
        hi_cnt  = 0;
        or_v    = '0;
        and_v   = '1;
      end
      if (in_win) begin
        win_len++;
        if (led_out !== '0) begin
          hi_cnt++;
          or_v  = or_v | led_out;
          and_v = and_v & led_out;
        end
      end
    end
  end

  task automatic do_reset(input int n);
    int bad = 0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (led_out !== '0 || pwm_wrap !== 1'b0) bad++;
    end
    reset_n = 1'b1;
    chk("reset_outputs", 32'(bad), 32'd0);
  endtask

  task automatic wait_wrap(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (pwm_wrap !== 1'b1 && k < 600);
    if (pwm_wrap !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: no pwm_wrap within 600 cycles", tag);
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() > 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL %s: %0d windows not observed", tag, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad_led, bad_wrap, k;
    reset_n     = 1'b0;
    led_pattern = '0;
    brightness  = '0;
    blink_en    = '0;

    // Reset holds outputs dark; LEDs stay dark until the first wrap loads brightness
    led_pattern = 10'h3FF;
    brightness  = 8'hFF;
    do_reset(3);
    bad_led  = 0;
    bad_wrap = 0;
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk);
      if (led_out !== '0) bad_led++;
      if (n < 256 && pwm_wrap !== 1'b0) bad_wrap++;
      if (n == 256) chk("first_wrap", 32'(pwm_wrap), 32'd1);
    end
    chk("dark_after_reset", 32'(bad_led), 32'd0);
    chk("no_early_wrap", 32'(bad_wrap), 32'd0);
    @(negedge clk);
    chk("full_on_after_wrap", 32'(led_out), 32'h3FF);

    // Full brightness passes the pattern steadily; brightness 0 darkens from the next period
    led_pattern = 10'h2A5;
    wait_wrap("full_on");
    @(negedge clk);
    push(256, 10'h2A5);
    drain("full_on");
    brightness = 8'h00;
    push(256, 10'h2A5);
    push(1, 10'h2A5);
    push(0, 10'h000);
    drain("to_dark");

    // 0x40 duty: 64 of 256 cycles on
    brightness  = 8'h40;
    led_pattern = 10'h3FF;
    push(0, 10'h000);
    push(64, 10'h3FF);
    push(64, 10'h3FF);
    drain("duty_40");

    // Mid-period change 0x40 -> 0xC0 at pwm_cnt 100
    wait_wrap("mid_change");
    repeat (100) @(negedge clk);
    brightness = 8'hC0;
    push(64, 10'h3FF);
    push(192, 10'h3FF);
    drain("mid_change");

    // Change on the pwm_cnt == max cycle applies one full period later
    wait_wrap("max_change");
    repeat (255) @(negedge clk);
    brightness = 8'h40;
    push(192, 10'h3FF);
    push(192, 10'h3FF);
    push(64, 10'h3FF);
    drain("max_change");

    // Blink with BLINK_DIV=4: bit0 4 on / 4 off, bit1 steady
    brightness  = 8'hFF;
    led_pattern = 10'h003;
    blink_en    = 10'h001;
    do_reset(1);
    wait_wrap("blink");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("blink_%0d", i), 32'(led_out), ((i / 4) % 2 == 0) ? 32'h3 : 32'h2);
    end

    // Pattern latency: drive before edge N+1, visible after edge N+2
    blink_en    = '0;
    led_pattern = '0;
    repeat (3) @(negedge clk);
    chk("pattern_zero", 32'(led_out), 32'h0);
    led_pattern = 10'h155;
    @(negedge clk);
    chk("pattern_lat_1", 32'(led_out), 32'h0);
    @(negedge clk);
    chk("pattern_lat_2", 32'(led_out), 32'h155);

    // One-cycle reset mid-period restarts the PWM counter from 0
    repeat (37) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_led", 32'(led_out), 32'h0);
    chk("midreset_wrap", 32'(pwm_wrap), 32'h0);
    reset_n = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (pwm_wrap !== 1'b1 && k < 600);
    chk("wrap_after_midreset", 32'(k), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
